// File: rtl/mem_arbiter.sv
// Shared main-memory arbiter for I-fill, D-fill and write-through traffic.
// Issues pipelined block bursts and steers returned words to the owning cache.
module mem_arbiter #(
   parameter int BLOCK_WORDS = 8,
   parameter int IDX_W       = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_req,
   input  logic [15:0]      i_addr,
   input  logic             d_req,
   input  logic [15:0]      d_addr,
   input  logic             wr_req,
   input  logic [15:0]      wr_addr,
   input  logic [15:0]      wr_data,
   output logic             i_busy,
   output logic             d_busy,
   output logic [15:0]      fill_data,
   output logic [IDX_W-1:0] fill_idx,
   output logic             i_fill_we,
   output logic             d_fill_we,
   output logic             i_done,
   output logic             d_done,
   output logic             wr_ack,
   output logic [15:0]      mem_addr,
   output logic             mem_en,
   output logic             mem_wr,
   output logic [15:0]      mem_wdata,
   input  logic [15:0]      mem_rdata,
   input  logic             mem_valid
);

   localparam int BASE_W = 16 - IDX_W - 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_WORDS - 1);
   localparam logic [IDX_W-1:0] ONE = IDX_W'(1);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, WRITE} state_t;
   typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} owner_t;

   state_t            state, stateNext;
   owner_t            owner, ownerNext;
   logic [BASE_W-1:0] base, baseNext;
   logic [IDX_W-1:0]  issueCnt, issueCntNext;
   logic [IDX_W-1:0]  rxCnt, rxCntNext;
   logic [15:0]       wrAddrQ, wrAddrNext;
   logic [15:0]       wrDataQ, wrDataNext;
   logic              accept;
   logic              lastRx;

   // Word-offset bits of the miss addresses are replaced by the burst index.
   logic unusedAddrBits;
   assign unusedAddrBits = ^{i_addr[IDX_W:0], d_addr[IDX_W:0]};

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         owner    <= OWN_NONE;
         base     <= '0;
         issueCnt <= '0;
         rxCnt    <= '0;
         wrAddrQ  <= '0;
         wrDataQ  <= '0;
      end else begin
         state    <= stateNext;
         owner    <= ownerNext;
         base     <= baseNext;
         issueCnt <= issueCntNext;
         rxCnt    <= rxCntNext;
         wrAddrQ  <= wrAddrNext;
         wrDataQ  <= wrDataNext;
      end
   end

   always_comb begin
      stateNext    = state;
      ownerNext    = owner;
      baseNext     = base;
      issueCntNext = issueCnt;
      rxCntNext    = rxCnt;
      wrAddrNext   = wrAddrQ;
      wrDataNext   = wrDataQ;
      accept = mem_valid && (state == ISSUE || state == DRAIN);
      lastRx = accept && (rxCnt == LAST_IDX);
      if (accept)
         rxCntNext = rxCnt + ONE;
      unique case (state)
         IDLE: begin
            if (d_req) begin
               stateNext = ISSUE;
               ownerNext = OWN_D;
               baseNext  = d_addr[15:IDX_W+1];
            end else if (wr_req) begin
               stateNext  = WRITE;
               wrAddrNext = wr_addr;
               wrDataNext = wr_data;
            end else if (i_req) begin
               stateNext = ISSUE;
               ownerNext = OWN_I;
               baseNext  = i_addr[15:IDX_W+1];
            end
         end
         ISSUE: begin
            issueCntNext = issueCnt + ONE;
            if (issueCnt == LAST_IDX)
               stateNext = DRAIN;
         end
         DRAIN: ;
         WRITE: stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
      // Final return ends the burst regardless of where issue stands.
      if (lastRx) begin
         stateNext    = IDLE;
         ownerNext    = OWN_NONE;
         issueCntNext = '0;
         rxCntNext    = '0;
      end
   end

   assign mem_en    = (state == ISSUE) || (state == WRITE);
   assign mem_wr    = (state == WRITE);
   assign mem_addr  = (state == ISSUE) ? {base, issueCnt, 1'b0} :
                      (state == WRITE) ? wrAddrQ : '0;
   assign mem_wdata = (state == WRITE) ? wrDataQ : '0;
   assign wr_ack    = (state == WRITE);

   assign fill_data = mem_rdata;
   assign fill_idx  = rxCnt;
   assign i_fill_we = accept && (owner == OWN_I);
   assign d_fill_we = accept && (owner == OWN_D);
   assign i_done    = lastRx && (owner == OWN_I);
   assign d_done    = lastRx && (owner == OWN_D);

   assign i_busy = i_req & ~i_done;
   assign d_busy = d_req & ~d_done;

endmodule
